// File: rtl/render_line_scheduler.sv
// Per-scanline render sequencer: starts prep then draw for line sy+2,
// arbitrates the OAM read port, owns buf_sel and counts missed deadlines.
//
// Ports:
//   clk_pix, btn_rst       pixel clock, async active-low reset
//   sx, sy                 current beam position from display_timings
//   prep_start/prep_done   line preparation handshake
//   draw_enable/draw_done  sprite drawer handshake
//   render_abort           one-cycle pulse returning both stages to idle
//   render_line            line number being rendered
//   prep_oam_addr, draw_oam_addr, oam_addr   OAM read port arbitration
//   buf_sel                buffer on display; rendering writes ~buf_sel
//   busy                   high while in PREP or DRAW
//   line_overrun           one-cycle pulse on a missed deadline
//   overrun_count          saturating count of missed deadlines
module render_line_scheduler #(
    parameter int CORDW         = 10,
    parameter int H_TOTAL       = 800,
    parameter int V_TOTAL       = 525,
    parameter int V_RES         = 480,
    parameter int OAM_ADDR_SIZE = 6
) (
    input  logic                     clk_pix,
    input  logic                     btn_rst,
    input  logic [CORDW-1:0]         sx,
    input  logic [CORDW-1:0]         sy,
    output logic                     prep_start,
    input  logic                     prep_done,
    output logic                     draw_enable,
    input  logic                     draw_done,
    output logic                     render_abort,
    output logic [CORDW-1:0]         render_line,
    input  logic [OAM_ADDR_SIZE-1:0] prep_oam_addr,
    input  logic [OAM_ADDR_SIZE-1:0] draw_oam_addr,
    output logic [OAM_ADDR_SIZE-1:0] oam_addr,
    output logic                     buf_sel,
    output logic                     busy,
    output logic                     line_overrun,
    output logic [7:0]               overrun_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DRAW,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW:0]   V_TOT  = (CORDW+1)'(V_TOTAL);
    localparam logic [CORDW:0]   V_VIS  = (CORDW+1)'(V_RES);

    state_t           state_q, state_d;
    logic             buf_sel_d;
    logic [CORDW-1:0] render_line_d;
    logic [7:0]       count_d;
    logic             prep_start_d;
    logic             abort_d;
    logic             draw_enable_d;
    logic             busy_d;
    logic [CORDW-1:0] pend_line_q, pend_line_d;
    logic             pend_valid_q, pend_valid_d;

    logic             trigger;
    logic [CORDW:0]   sum;
    logic [CORDW:0]   tgt;
    logic             tgt_valid;
    logic             finished;
    logic             late;

    assign trigger   = (sx == H_LAST);
    assign sum       = {1'b0, sy} + (CORDW+1)'(2);
    assign tgt       = (sum >= V_TOT) ? (sum - V_TOT) : sum;
    assign tgt_valid = (tgt < V_VIS);

    // A line is finished if DONE, or if draw_done lands on the trigger.
    assign finished = (state_q == S_DONE) ||
                      (state_q == S_DRAW && draw_done);
    assign late     = (state_q == S_PREP) ||
                      (state_q == S_DRAW && !draw_done);

    always_comb begin
        state_d       = state_q;
        buf_sel_d     = buf_sel;
        render_line_d = render_line;
        count_d       = overrun_count;
        prep_start_d  = 1'b0;
        abort_d       = 1'b0;
        pend_line_d   = pend_line_q;
        pend_valid_d  = pend_valid_q;

        unique case (state_q)
            S_PREP:  if (prep_done) state_d = S_DRAW;
            S_DRAW:  if (draw_done) state_d = S_DONE;
            S_ABORT: begin
                if (pend_valid_q) begin
                    render_line_d = pend_line_q;
                    prep_start_d  = 1'b1;
                    state_d       = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (trigger && state_q != S_ABORT) begin
            if (late) begin
                // Missed deadline: keep showing the old buffer.
                abort_d      = 1'b1;
                pend_line_d  = tgt[CORDW-1:0];
                pend_valid_d = tgt_valid;
                state_d      = S_ABORT;
                if (overrun_count != 8'hFF)
                    count_d = overrun_count + 8'd1;
            end else begin
                if (finished)
                    buf_sel_d = ~buf_sel;
                if (tgt_valid) begin
                    render_line_d = tgt[CORDW-1:0];
                    prep_start_d  = 1'b1;
                    state_d       = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end

        draw_enable_d = (state_d == S_DRAW);
        busy_d        = (state_d == S_PREP) || (state_d == S_DRAW);
    end

    always_ff @(posedge clk_pix or negedge btn_rst) begin
        if (!btn_rst) begin
            state_q       <= S_IDLE;
            buf_sel       <= 1'b0;
            render_line   <= '0;
            overrun_count <= '0;
            prep_start    <= 1'b0;
            render_abort  <= 1'b0;
            line_overrun  <= 1'b0;
            draw_enable   <= 1'b0;
            busy          <= 1'b0;
            pend_line_q   <= '0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_sel       <= buf_sel_d;
            render_line   <= render_line_d;
            overrun_count <= count_d;
            prep_start    <= prep_start_d;
            render_abort  <= abort_d;
            line_overrun  <= abort_d;
            draw_enable   <= draw_enable_d;
            busy          <= busy_d;
            pend_line_q   <= pend_line_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

    assign oam_addr = (state_q == S_DRAW) ? draw_oam_addr : prep_oam_addr;

endmodule

// File: tb/tb_render_line_scheduler.sv
// Directed testbench for render_line_scheduler.
// Drives sx/sy triggers and prep/draw handshakes, checks outputs.
module tb_render_line_scheduler;

    logic       clk_pix = 1'b0;
    logic       btn_rst = 1'b0;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic       prep_start;
    logic       prep_done = 1'b0;
    logic       draw_enable;
    logic       draw_done = 1'b0;
    logic       render_abort;
    logic [9:0] render_line;
    logic [5:0] prep_oam_addr = 6'd5;
    logic [5:0] draw_oam_addr = 6'd9;
    logic [5:0] oam_addr;
    logic       buf_sel;
    logic       busy;
    logic       line_overrun;
    logic [7:0] overrun_count;

    int checks = 0;
    int errors = 0;

    render_line_scheduler dut (
        .clk_pix       (clk_pix),
        .btn_rst       (btn_rst),
        .sx            (sx),
        .sy            (sy),
        .prep_start    (prep_start),
        .prep_done     (prep_done),
        .draw_enable   (draw_enable),
        .draw_done     (draw_done),
        .render_abort  (render_abort),
        .render_line   (render_line),
        .prep_oam_addr (prep_oam_addr),
        .draw_oam_addr (draw_oam_addr),
        .oam_addr      (oam_addr),
        .buf_sel       (buf_sel),
        .busy          (busy),
        .line_overrun  (line_overrun),
        .overrun_count (overrun_count)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Present the last pixel of line s for one edge, then move on.
    task automatic trig(input int s);
        sx = 10'd799;
        sy = 10'(s);
        tick();
        sx = 10'd0;
        sy = 10'((s + 1) % 525);
    endtask

    task automatic test_reset();
        int starts;
        btn_rst = 1'b0;
        tick();
        tick();
        btn_rst = 1'b1;
        tick();
        checks++;
        if ({prep_start, draw_enable, render_abort, buf_sel, busy,
             line_overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {prep_start, draw_enable, render_abort, buf_sel,
                      busy, line_overrun});
        end
        checks++;
        if (render_line !== 10'd0 || overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs got %0d/%0d want 0/0",
                     render_line, overrun_count);
        end
        checks++;
        if (oam_addr !== 6'd5) begin
            errors++;
            $display("FAIL reset_oam got %0d want 5", oam_addr);
        end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            sx = 10'(i);
            tick();
            if (prep_start || busy) starts++;
        end
        sx = 10'd0;
        checks++;
        if (starts !== 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d want 0", starts);
        end
    endtask

    task automatic test_normal();
        int de_cnt;
        trig(10);
        checks++;
        if (prep_start !== 1'b1 || render_line !== 10'd12) begin
            errors++;
            $display("FAIL norm_start got %b/%0d want 1/12",
                     prep_start, render_line);
        end
        checks++;
        if (busy !== 1'b1 || draw_enable !== 1'b0 ||
            oam_addr !== 6'd5 || buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL norm_prep got %b%b/%0d/%b want 10/5/0",
                     busy, draw_enable, oam_addr, buf_sel);
        end
        tick();
        checks++;
        if (prep_start !== 1'b0) begin
            errors++;
            $display("FAIL norm_pulse got %b want 0", prep_start);
        end
        repeat (48) tick();
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        checks++;
        if (draw_enable !== 1'b1 || oam_addr !== 6'd9) begin
            errors++;
            $display("FAIL norm_draw got %b/%0d want 1/9",
                     draw_enable, oam_addr);
        end
        de_cnt = 1;
        for (int i = 0; i < 199; i++) begin
            tick();
            if (draw_enable) de_cnt++;
        end
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        checks++;
        if (de_cnt !== 200) begin
            errors++;
            $display("FAIL norm_de_len got %0d want 200", de_cnt);
        end
        checks++;
        if (draw_enable !== 1'b0 || busy !== 1'b0 ||
            oam_addr !== 6'd5 || buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL norm_done got %b%b/%0d/%b want 00/5/0",
                     draw_enable, busy, oam_addr, buf_sel);
        end
        trig(11);
        checks++;
        if (buf_sel !== 1'b1 || prep_start !== 1'b1 ||
            render_line !== 10'd13) begin
            errors++;
            $display("FAIL norm_toggle got %b/%b/%0d want 1/1/13",
                     buf_sel, prep_start, render_line);
        end
    endtask

    task automatic test_back_to_back();
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        draw_done = 1'b1;
        trig(12);
        draw_done = 1'b0;
        checks++;
        if (line_overrun !== 1'b0 || render_abort !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_ovr got %b/%b want 0/0",
                     line_overrun, render_abort);
        end
        checks++;
        if (buf_sel !== 1'b0 || prep_start !== 1'b1 ||
            render_line !== 10'd14) begin
            errors++;
            $display("FAIL b2b_start got %b/%b/%0d want 0/1/14",
                     buf_sel, prep_start, render_line);
        end
    endtask

    task automatic test_overrun();
        int ab_cnt;
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        trig(13);
        checks++;
        if (render_abort !== 1'b1 || line_overrun !== 1'b1 ||
            overrun_count !== 8'd1) begin
            errors++;
            $display("FAIL ovr_pulse got %b/%b/%0d want 1/1/1",
                     render_abort, line_overrun, overrun_count);
        end
        checks++;
        if (buf_sel !== 1'b0 || prep_start !== 1'b0 ||
            draw_enable !== 1'b0) begin
            errors++;
            $display("FAIL ovr_state got %b/%b/%b want 0/0/0",
                     buf_sel, prep_start, draw_enable);
        end
        tick();
        checks++;
        if (render_abort !== 1'b0 || prep_start !== 1'b1 ||
            render_line !== 10'd15 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_restart got %b/%b/%0d/%b want 0/1/15/1",
                     render_abort, prep_start, render_line, busy);
        end
        ab_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            trig(20);
            if (line_overrun) ab_cnt++;
            tick();
            if (line_overrun) ab_cnt++;
        end
        checks++;
        if (ab_cnt !== 300) begin
            errors++;
            $display("FAIL ovr_pulses got %0d want 300", ab_cnt);
        end
        checks++;
        if (overrun_count !== 8'd255 || buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sat got %0d/%b want 255/0",
                     overrun_count, buf_sel);
        end
    endtask

    task automatic test_wrap();
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        trig(478);
        checks++;
        if (buf_sel !== 1'b1 || prep_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_478 got %b/%b/%b want 1/0/0",
                     buf_sel, prep_start, busy);
        end
        trig(479);
        trig(521);
        trig(522);
        checks++;
        if (buf_sel !== 1'b1 || prep_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_blank got %b/%b/%b want 1/0/0",
                     buf_sel, prep_start, busy);
        end
        trig(523);
        checks++;
        if (prep_start !== 1'b1 || render_line !== 10'd0 ||
            buf_sel !== 1'b1) begin
            errors++;
            $display("FAIL wrap_523 got %b/%0d/%b want 1/0/1",
                     prep_start, render_line, buf_sel);
        end
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        trig(524);
        checks++;
        if (prep_start !== 1'b1 || render_line !== 10'd1 ||
            buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL wrap_524 got %b/%0d/%b want 1/1/0",
                     prep_start, render_line, buf_sel);
        end
    endtask

    task automatic test_reset_mid();
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        checks++;
        if (oam_addr !== 6'd9 || draw_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_draw got %0d/%b want 9/1",
                     oam_addr, draw_enable);
        end
        #2;
        btn_rst = 1'b0;
        #1;
        checks++;
        if (oam_addr !== 6'd5 || draw_enable !== 1'b0 ||
            busy !== 1'b0 || overrun_count !== 8'd0 ||
            render_line !== 10'd1) begin
            if (render_line !== 10'd0 || oam_addr !== 6'd5 ||
                draw_enable !== 1'b0 || busy !== 1'b0 ||
                overrun_count !== 8'd0) begin
                errors++;
                $display("FAIL mid_rst got %0d/%b%b/%0d/%0d want 5/00/0/0",
                         oam_addr, draw_enable, busy, overrun_count,
                         render_line);
            end
        end
        checks++;
        if (buf_sel !== 1'b0 || prep_start !== 1'b0 ||
            render_abort !== 1'b0 || line_overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_flags got %b%b%b%b want 0000",
                     buf_sel, prep_start, render_abort, line_overrun);
        end
        tick();
        btn_rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_overrun();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
